// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int GROUP_W = 4;

    // Counter must reach WIDTH after its last increment, hence the extra bit.
    function automatic int div_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_subtractor.sv
// Trial subtract A - B as A + ~B + 1: partial full adder cells with
// 4-bit group carry lookahead, rippling between groups.
module seq_restoring_divider_subtractor
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = 33
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Diff,
    output logic         NoBorrow
);

    localparam int NG = (N + GROUP_W - 1) / GROUP_W;

    logic [N-1:0] b_inv;
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    for (genvar i = 0; i < N; i++) begin : g_pfa
        assign b_inv[i] = ~B[i];
        assign gen[i]   = A[i] & b_inv[i];
        assign prop[i]  = A[i] ^ b_inv[i];
        assign Diff[i]  = prop[i] ^ carry[i];
    end

    // Each carry inside a group is a sum of products over that group's
    // generate/propagate terms and the group carry-in.
    always_comb begin
        logic gen_t;
        logic prop_t;
        gen_t    = 1'b0;
        prop_t   = 1'b1;
        carry    = '0;
        carry[0] = 1'b1;
        for (int grp = 0; grp < NG; grp++) begin
            for (int j = 1; j <= GROUP_W; j++) begin
                if (grp * GROUP_W + j <= N) begin
                    gen_t  = 1'b0;
                    prop_t = 1'b1;
                    for (int k = grp * GROUP_W + j - 1; k >= grp * GROUP_W; k--) begin
                        gen_t  = gen_t | (prop_t & gen[k]);
                        prop_t = prop_t & prop[k];
                    end
                    carry[grp * GROUP_W + j] = gen_t | (prop_t & carry[grp * GROUP_W]);
                end
            end
        end
    end

    assign NoBorrow = carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multicycle unsigned restoring divider (DIVU), one quotient bit per cycle.
// Zero divisor completes in one cycle with all-ones quotient and DivByZero.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int             CW       = div_cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             diff_msb_unused;

    assign trial_a = {r_q, q_q[WIDTH-1]};
    assign trial_b = {1'b0, d_q};

    seq_restoring_divider_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .A        (trial_a),
        .B        (trial_b),
        .Diff     (diff),
        .NoBorrow (no_borrow)
    );

    // The partial remainder stays below the divisor, so a successful
    // subtract never sets the top difference bit.
    assign diff_msb_unused = diff[WIDTH];

    assign accept = Start && (state_q != DIV_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        dbz_d   = dbz_q;
        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                if (accept) begin
                    d_d   = Divisor;
                    cnt_d = '0;
                    if (Divisor == '0) begin
                        state_d = DIV_DONE;
                        q_d     = '1;
                        r_d     = Dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = DIV_RUN;
                        q_d     = Dividend;
                        r_d     = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DIV_RUN: begin
                r_d   = no_borrow ? diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_DONE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Busy      = (state_q == DIV_RUN);
    assign Done      = (state_q == DIV_DONE);
    assign Quotient  = q_q;
    assign Remainder = r_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench: WIDTH=8 and WIDTH=32 dividers, directed vectors plus a
// short randomized batch checked against / and %.
module tb_seq_restoring_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst8 = 1'b1, rst32 = 1'b1;
    logic        start8 = 1'b0, start32 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy8, done8, dbz8, busy32, done32, dbz32;
    logic [7:0]  q8, r8;
    logic [31:0] q32, r32;

    int checks = 0;
    int errors = 0;

    exp_t sb8[$];
    exp_t sb32[$];
    exp_t e8, e32;
    bit   pend8 = 0, pend32 = 0;
    int   cyc8, bcnt8, cyc32, bcnt32;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(8)) u_div8 (
        .CLK(clk), .RST(rst8), .Start(start8), .Dividend(a8), .Divisor(b8),
        .Busy(busy8), .Done(done8), .Quotient(q8), .Remainder(r8), .DivByZero(dbz8)
    );

    seq_restoring_divider #(.WIDTH(32)) u_div32 (
        .CLK(clk), .RST(rst32), .Start(start32), .Dividend(a32), .Divisor(b32),
        .Busy(busy32), .Done(done32), .Quotient(q32), .Remainder(r32), .DivByZero(dbz32)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept detection uses pre-edge values, same as the DUT sees them.
    always @(posedge clk) begin
        if (rst8) pend8 = 0;
        else if (start8 && !busy8) begin pend8 = 1; cyc8 = 0; bcnt8 = 0; end
        if (rst32) pend32 = 0;
        else if (start32 && !busy32) begin pend32 = 1; cyc32 = 0; bcnt32 = 0; end
    end

    always @(negedge clk) begin
        if (pend8) begin
            cyc8++;
            if (busy8) bcnt8++;
            if (done8) begin
                pend8 = 0;
                if (sb8.size() == 0) chk("sb8_empty", 32'd1, 32'd0);
                else begin
                    e8 = sb8.pop_front();
                    chk("w8_quotient", {24'd0, q8}, e8.q);
                    chk("w8_remainder", {24'd0, r8}, e8.r);
                    chk("w8_divbyzero", {31'd0, dbz8}, {31'd0, e8.dbz});
                    chk("w8_latency", cyc8, e8.lat);
                    chk("w8_busy_cycles", bcnt8, e8.busy);
                end
            end else if (cyc8 > 100) begin
                pend8 = 0;
                chk("w8_done_timeout", cyc8, 32'd9);
            end
        end
        if (pend32) begin
            cyc32++;
            if (busy32) bcnt32++;
            if (done32) begin
                pend32 = 0;
                if (sb32.size() == 0) chk("sb32_empty", 32'd1, 32'd0);
                else begin
                    e32 = sb32.pop_front();
                    chk("w32_quotient", q32, e32.q);
                    chk("w32_remainder", r32, e32.r);
                    chk("w32_divbyzero", {31'd0, dbz32}, {31'd0, e32.dbz});
                    chk("w32_latency", cyc32, e32.lat);
                    chk("w32_busy_cycles", bcnt32, e32.busy);
                end
            end else if (cyc32 > 100) begin
                pend32 = 0;
                chk("w32_done_timeout", cyc32, 32'd33);
            end
        end
    end

    task automatic push8(input logic [7:0] b, input logic [7:0] q, input logic [7:0] r, input logic dbz);
        exp_t e;
        e.q = {24'd0, q}; e.r = {24'd0, r}; e.dbz = dbz;
        e.lat = (b == 0) ? 1 : 9;
        e.busy = (b == 0) ? 0 : 8;
        sb8.push_back(e);
    endtask

    task automatic push32(input logic [31:0] b, input logic [31:0] q, input logic [31:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        e.lat = (b == 0) ? 1 : 33;
        e.busy = (b == 0) ? 0 : 32;
        sb32.push_back(e);
    endtask

    task automatic drain8();
        for (int i = 0; i < 200 && sb8.size() != 0; i++) @(negedge clk);
        if (sb8.size() != 0) begin
            chk("w8_drain_timeout", sb8.size(), 32'd0);
            sb8.delete();
        end
    endtask

    task automatic drain32();
        for (int i = 0; i < 200 && sb32.size() != 0; i++) @(negedge clk);
        if (sb32.size() != 0) begin
            chk("w32_drain_timeout", sb32.size(), 32'd0);
            sb32.delete();
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input logic dbz);
        push8(b, q, r, dbz);
        @(negedge clk); start8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk); start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
        drain8();
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic dbz);
        push32(b, q, r, dbz);
        @(negedge clk); start32 = 1'b1; a32 = a; b32 = b;
        @(negedge clk); start32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'h12345678;
        drain32();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int gap;

        repeat (3) @(negedge clk);
        chk("rst8_busy", {31'd0, busy8}, 32'd0);
        chk("rst8_done", {31'd0, done8}, 32'd0);
        chk("rst8_dbz", {31'd0, dbz8}, 32'd0);
        chk("rst8_q", {24'd0, q8}, 32'd0);
        chk("rst8_r", {24'd0, r8}, 32'd0);
        chk("rst32_busy", {31'd0, busy32}, 32'd0);
        chk("rst32_done", {31'd0, done32}, 32'd0);
        chk("rst32_dbz", {31'd0, dbz32}, 32'd0);
        chk("rst32_q", q32, 32'd0);
        chk("rst32_r", r32, 32'd0);
        rst8 = 1'b0; rst32 = 1'b0;

        // WIDTH=8 directed
        op8(8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
        op8(8'd5,   8'd9,   8'd0,   8'd5,   1'b0);
        op8(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
        op8(8'd255, 8'd255, 8'd1,   8'd0,   1'b0);
        op8(8'd7,   8'd0,   8'hFF,  8'd7,   1'b1);
        op8(8'd0,   8'd5,   8'd0,   8'd0,   1'b0);
        op8(8'd128, 8'd3,   8'd42,  8'd2,   1'b0);

        // Start pulses during RUN are ignored, then Start held into DONE
        push8(8'd7, 8'd14, 8'd2, 1'b0);
        @(negedge clk); start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); start8 = 1'b1; a8 = 8'd50; b8 = 8'd3;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); start8 = 1'b1; a8 = 8'd9; b8 = 8'd0;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        push8(8'd13, 8'd15, 8'd5, 1'b0);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd13;
        for (int i = 0; i < 50 && !done8; i++) @(negedge clk);
        gap = 0;
        while (!busy8 && gap < 50) begin @(negedge clk); gap++; end
        start8 = 1'b0;
        chk("w8_back_to_back_gap", gap, 32'd1);
        drain8();

        // Reset in the middle of RUN
        @(negedge clk); start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy8}, 32'd0);
        chk("midrst_done", {31'd0, done8}, 32'd0);
        chk("midrst_dbz", {31'd0, dbz8}, 32'd0);
        chk("midrst_q", {24'd0, q8}, 32'd0);
        chk("midrst_r", {24'd0, r8}, 32'd0);
        rst8 = 1'b0;
        op8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

        for (int n = 0; n < 25; n++) begin
            ra = {24'd0, 8'($urandom)};
            rb = {24'd0, 8'($urandom_range(1, 255))};
            op8(ra[7:0], rb[7:0], 8'(ra / rb), 8'(ra % rb), 1'b0);
        end

        // WIDTH=32 directed
        op32(32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0);
        op32(32'd42, 32'd0, 32'hFFFFFFFF, 32'd42, 1'b1);
        op32(32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
        op32(32'd1000000, 32'd7, 32'd142857, 32'd1, 1'b0);
        op32(32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0);
        op32(32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1);
        op32(32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 1'b0);

        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 0) rb = 32'd1;
            op32(ra, rb, ra / rb, ra % rb, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
